// File: rtl/gpu_host_pkg.sv
// Shared widths, read-tag type and data formatting helpers for the GPU RAM host port.
package gpu_host_pkg;

    localparam int HOST_ADDR_W = 20;
    localparam int HOST_DATA_W = 16;

    typedef struct packed {
        logic valid;
        logic is16;
    } host_tag_t;

    // 8-bit writes put the byte on both lanes so the RAM can pick either half.
    function automatic logic [HOST_DATA_W-1:0] format_wdata(input logic is16,
                                                            input logic [HOST_DATA_W-1:0] data);
        return is16 ? data : {data[7:0], data[7:0]};
    endfunction

    function automatic logic [HOST_DATA_W-1:0] format_rdata(input logic is16,
                                                            input logic [HOST_DATA_W-1:0] data);
        return is16 ? data : {8'h00, data[7:0]};
    endfunction

endpackage

// File: rtl/host_rsp_fifo.sv
// First-word-fall-through response FIFO; head entry is visible whenever it is non-empty.
module host_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             not_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             full;

    assign not_empty = (count != '0);
    assign full      = (count == FULL_COUNT);
    assign do_pop    = pop && not_empty;
    assign pop_data  = mem[rd_ptr];

    // Pointers are power-of-two wide, so they wrap on their own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Credit flow control upstream must make overflow impossible.
    assert property (@(posedge clk) disable iff (!reset_n) !(push && full));

endmodule

// File: rtl/host_mem_sequencer.sv
// Sequences host read/write requests onto the GPU RAM host port and returns read data in order.
module host_mem_sequencer
    import gpu_host_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic                   req_16bit,
    input  logic [HOST_ADDR_W-1:0] req_addr,
    input  logic [HOST_DATA_W-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [HOST_DATA_W-1:0] rsp_data,
    output logic                   ram_wena,
    output logic                   ram_16bit,
    output logic [HOST_ADDR_W-1:0] ram_addr,
    output logic [HOST_DATA_W-1:0] ram_wdata,
    input  logic [HOST_DATA_W-1:0] ram_rdata,
    output logic [4:0]             outstanding
);

    localparam logic [4:0] CREDITS = 5'(RESP_DEPTH);

    logic                   accept;
    logic                   read_accept;
    logic                   pop;
    logic                   push;
    logic [HOST_DATA_W-1:0] push_data;
    logic [4:0]             outstanding_next;

    logic                   acc_valid;
    logic                   acc_write;
    logic                   acc_16bit;
    logic [HOST_ADDR_W-1:0] acc_addr;
    logic [HOST_DATA_W-1:0] acc_wdata;

    host_tag_t              ram_tag;
    host_tag_t              tag_sr [READ_LATENCY];

    assign accept      = req_valid && req_ready;
    assign read_accept = accept && !req_write;
    assign pop         = rsp_valid && rsp_ready;

    // Capture stage: the RAM port is driven one edge after acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_valid <= 1'b0;
            acc_write <= 1'b0;
            acc_16bit <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
        end else begin
            acc_valid <= accept;
            if (accept) begin
                acc_write <= req_write;
                acc_16bit <= req_16bit;
                acc_addr  <= req_addr;
                acc_wdata <= format_wdata(req_16bit, req_wdata);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_wena  <= 1'b0;
            ram_16bit <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_tag   <= '0;
        end else begin
            ram_wena      <= acc_valid && acc_write;
            ram_tag.valid <= acc_valid && !acc_write;
            ram_tag.is16  <= acc_16bit;
            if (acc_valid) begin
                ram_16bit <= acc_16bit;
                ram_addr  <= acc_addr;
                ram_wdata <= acc_wdata;
            end
        end
    end

    // The last tag stage lines up with the cycle ram_rdata is valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            tag_sr[0] <= ram_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    assign push      = tag_sr[READ_LATENCY-1].valid;
    assign push_data = format_rdata(tag_sr[READ_LATENCY-1].is16, ram_rdata);

    always_comb begin
        outstanding_next = outstanding;
        if (read_accept && !pop) begin
            outstanding_next = outstanding + 5'd1;
        end else if (pop && !read_accept) begin
            outstanding_next = outstanding - 5'd1;
        end
    end

    // Ready tracks the post-update credit count so it never lags by a cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
            req_ready   <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            req_ready   <= (outstanding_next < CREDITS);
        end
    end

    host_rsp_fifo #(
        .DEPTH(RESP_DEPTH),
        .WIDTH(HOST_DATA_W)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_data(push_data),
        .pop      (rsp_ready),
        .pop_data (rsp_data),
        .not_empty(rsp_valid)
    );

endmodule

// File: tb/tb_host_mem_sequencer.sv
// Directed bench for host_mem_sequencer with a fixed-latency RAM model (data = addr[15:0] ^ 16'hC3D4).
module tb_host_mem_sequencer;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_16bit;
    logic [19:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        ram_wena;
    logic        ram_16bit;
    logic [19:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [4:0]  outstanding;

    int pass_count  = 0;
    int check_count = 0;

    logic [15:0] rd_pipe [2];

    host_mem_sequencer #(
        .READ_LATENCY(2),
        .RESP_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_16bit  (req_16bit),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .ram_wena   (ram_wena),
        .ram_16bit  (ram_16bit),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle RAM: data is valid two edges after the address is presented.
    always @(posedge clk) begin
        rd_pipe[0] <= ram_addr[15:0] ^ 16'hC3D4;
        rd_pipe[1] <= rd_pipe[0];
    end
    assign ram_rdata = rd_pipe[1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count = check_count + 1;
        assert (observed === expected) pass_count = pass_count + 1;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic drive_req(input logic valid, input logic write, input logic is16,
                             input logic [19:0] addr, input logic [15:0] wdata);
        req_valid = valid;
        req_write = write;
        req_16bit = is16;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    initial begin
        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;

        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_ram_wena", 32'(ram_wena), 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_outstanding", 32'(outstanding), 32'h0);

        reset_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(req_ready), 32'h0);
        tick();
        check("ready_after_release", 32'(req_ready), 32'h1);

        // 16-bit write
        drive_req(1'b1, 1'b1, 1'b1, 20'h00100, 16'hBEEF);
        tick();
        drive_req(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        check("wr16_wena_at_N", 32'(ram_wena), 32'h0);
        tick();
        check("wr16_wena_N1", 32'(ram_wena), 32'h1);
        check("wr16_addr", 32'(ram_addr), 32'h00100);
        check("wr16_wdata", 32'(ram_wdata), 32'hBEEF);
        check("wr16_16bit", 32'(ram_16bit), 32'h1);
        tick();
        check("wr16_wena_drop", 32'(ram_wena), 32'h0);
        check("wr16_addr_hold", 32'(ram_addr), 32'h00100);
        check("wr_outstanding", 32'(outstanding), 32'h0);

        // 8-bit write
        drive_req(1'b1, 1'b1, 1'b0, 20'h00200, 16'h12A5);
        tick();
        drive_req(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        tick();
        check("wr8_wena", 32'(ram_wena), 32'h1);
        check("wr8_wdata", 32'(ram_wdata), 32'hA5A5);
        check("wr8_16bit", 32'(ram_16bit), 32'h0);
        check("wr8_addr", 32'(ram_addr), 32'h00200);

        // 8-bit read of address 0 (RAM returns C3D4)
        drive_req(1'b1, 1'b0, 1'b0, 20'h00000, 16'h0);
        tick();
        drive_req(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        check("rd8_outstanding", 32'(outstanding), 32'h1);
        tick();
        check("rd8_wena_low", 32'(ram_wena), 32'h0);
        tick();
        tick();
        check("rd8_not_early", 32'(rsp_valid), 32'h0);
        tick();
        check("rd8_valid", 32'(rsp_valid), 32'h1);
        check("rd8_data", 32'(rsp_data), 32'h00D4);
        tick();
        check("rd8_data_stable", 32'(rsp_data), 32'h00D4);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd8_popped", 32'(rsp_valid), 32'h0);
        check("rd8_out_zero", 32'(outstanding), 32'h0);

        // 16-bit read of address 0
        drive_req(1'b1, 1'b0, 1'b1, 20'h00000, 16'h0);
        tick();
        drive_req(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        repeat (4) tick();
        check("rd16_valid", 32'(rsp_valid), 32'h1);
        check("rd16_data", 32'(rsp_data), 32'hC3D4);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd16_popped", 32'(outstanding), 32'h0);

        // Six back-to-back reads with responses blocked: only four credits
        for (int i = 1; i <= 4; i++) begin
            drive_req(1'b1, 1'b0, 1'b1, 20'(i), 16'h0);
            tick();
        end
        drive_req(1'b1, 1'b0, 1'b1, 20'h00005, 16'h0);
        check("b2b_ready_drop", 32'(req_ready), 32'h0);
        check("b2b_out4", 32'(outstanding), 32'h4);
        repeat (6) tick();
        check("b2b_out_hold", 32'(outstanding), 32'h4);
        check("b2b_ready_low", 32'(req_ready), 32'h0);
        check("b2b_head", 32'(rsp_data), 32'hC3D5);

        rsp_ready = 1'b1;
        tick();
        check("drain1_data", 32'(rsp_data), 32'hC3D6);
        check("drain1_ready", 32'(req_ready), 32'h1);
        check("drain1_out", 32'(outstanding), 32'h3);
        tick();
        drive_req(1'b1, 1'b0, 1'b1, 20'h00006, 16'h0);
        check("drain2_data", 32'(rsp_data), 32'hC3D7);
        check("drain2_out", 32'(outstanding), 32'h3);
        tick();
        drive_req(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        check("drain3_data", 32'(rsp_data), 32'hC3D0);
        check("drain3_out", 32'(outstanding), 32'h3);
        tick();
        check("drain4_empty", 32'(rsp_valid), 32'h0);
        check("drain4_out", 32'(outstanding), 32'h2);
        tick();
        check("drain5_empty", 32'(rsp_valid), 32'h0);
        tick();
        check("drain6_valid", 32'(rsp_valid), 32'h1);
        check("drain6_data", 32'(rsp_data), 32'hC3D1);
        check("drain6_out", 32'(outstanding), 32'h2);
        tick();
        check("drain7_data", 32'(rsp_data), 32'hC3D2);
        check("drain7_out", 32'(outstanding), 32'h1);
        tick();
        rsp_ready = 1'b0;
        check("drain8_empty", 32'(rsp_valid), 32'h0);
        check("drain8_out", 32'(outstanding), 32'h0);

        // Push and pop on the same edge at occupancy 2
        for (int i = 7; i <= 9; i++) begin
            drive_req(1'b1, 1'b0, 1'b1, 20'(i), 16'h0);
            tick();
        end
        drive_req(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        repeat (3) tick();
        check("pp_out_before", 32'(outstanding), 32'h3);
        check("pp_head_before", 32'(rsp_data), 32'hC3D3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("pp_out_after", 32'(outstanding), 32'h2);
        check("pp_head_after", 32'(rsp_data), 32'hC3DC);
        rsp_ready = 1'b1;
        tick();
        check("pp_next", 32'(rsp_data), 32'hC3DD);
        check("pp_next_out", 32'(outstanding), 32'h1);
        tick();
        rsp_ready = 1'b0;
        check("pp_empty", 32'(rsp_valid), 32'h0);

        // Reset with two reads in flight
        drive_req(1'b1, 1'b0, 1'b1, 20'h0000A, 16'h0);
        tick();
        drive_req(1'b1, 1'b0, 1'b1, 20'h0000B, 16'h0);
        tick();
        drive_req(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        tick();
        check("inflight_out", 32'(outstanding), 32'h2);
        reset_n = 1'b0;
        #1;
        check("async_req_ready", 32'(req_ready), 32'h0);
        check("async_ram_wena", 32'(ram_wena), 32'h0);
        check("async_ram_16bit", 32'(ram_16bit), 32'h0);
        check("async_ram_addr", 32'(ram_addr), 32'h0);
        check("async_ram_wdata", 32'(ram_wdata), 32'h0);
        check("async_rsp_valid", 32'(rsp_valid), 32'h0);
        check("async_rsp_data", 32'(rsp_data), 32'h0);
        check("async_outstanding", 32'(outstanding), 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_reset_no_rsp", 32'(rsp_valid), 32'h0);
        end
        check("post_reset_out", 32'(outstanding), 32'h0);
        check("post_reset_ready", 32'(req_ready), 32'h1);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
